dds_sweep_ctrl: RTL

Frequency-sweep sequencer that sits directly upstream of the DDS core and drives its 32-bit frequency tuning word input. On a Start command it steps Fword from a start word to a stop word in fixed increments. Each value is held for a programmable number of clock cycles. It supports up or down sweeps, one-shot or continuous looping, and abort. Phase word and waveform select go to the DDS core separately and are not handled here.

---
 rtl/dds_sweep_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS tuning word: steps Start->Stop, holding each point max(Dwell,1) cycles.
// Latency: Start sampled at edge k, first Fword at edge k+1; no backpressure, Abort freezes Fword and drops Busy.
module dds_sweep_ctrl #(
    parameter int FW_W    = 32,
    parameter int DWELL_W = 24
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Loop,
    input  logic [FW_W-1:0]    Start_fword,
    input  logic [FW_W-1:0]    Stop_fword,
    input  logic [FW_W-1:0]    Step_fword,
    input  logic [DWELL_W-1:0] Dwell,
    output logic [FW_W-1:0]    Fword,
    output logic               Busy,
    output logic               Step_strobe,
    output logic               Done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [FW_W-1:0]    r_fword, w_fword_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_strobe, w_strobe_nxt;
    logic               r_done, w_done_nxt;
    logic               w_capture;

    logic [FW_W-1:0]    r_start, r_stop, r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_loop, r_up;

    logic [DWELL_W-1:0] w_cnt_init;
    logic [FW_W:0]      w_sum, w_diff;
    logic [FW_W-1:0]    w_next_pt;
    logic               w_last;

    // Dwell of 0 behaves as 1, so the countdown reload is max(Dwell,1)-1.
    assign w_cnt_init = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
    assign w_sum      = {1'b0, r_fword} + {1'b0, r_step};
    assign w_diff     = {1'b0, r_fword} - {1'b0, r_step};
    assign w_last     = (r_fword == r_stop) || (r_step == '0);

    // Carry/borrow out of the widened result clamps to Stop instead of wrapping.
    always_comb begin
        w_next_pt = w_sum[FW_W-1:0];
        if (r_up) begin
            if (w_sum[FW_W] || (w_sum[FW_W-1:0] >= r_stop))
                w_next_pt = r_stop;
        end else begin
            w_next_pt = w_diff[FW_W-1:0];
            if (w_diff[FW_W] || (w_diff[FW_W-1:0] <= r_stop))
                w_next_pt = r_stop;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fword_nxt  = r_fword;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (Start && !Abort) begin
                    w_state_nxt = S_LOAD;
                    w_capture   = 1'b1;
                end
            end
            S_LOAD: begin
                if (Abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt  = S_RUN;
                    w_fword_nxt  = r_start;
                    w_busy_nxt   = 1'b1;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = w_cnt_init;
                end
            end
            S_RUN: begin
                if (Abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DWELL_W'(1);
                end else if (w_last && !r_loop) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_fword_nxt  = w_last ? r_start : w_next_pt;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = w_cnt_init;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fword  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_loop   <= 1'b0;
            r_up     <= 1'b1;
        end else begin
            r_fword  <= w_fword_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
            if (w_capture) begin
                r_start <= Start_fword;
                r_stop  <= Stop_fword;
                r_step  <= Step_fword;
                r_dwell <= Dwell;
                r_loop  <= Loop;
                r_up    <= (Start_fword <= Stop_fword);
            end
        end
    end

    assign Fword       = r_fword;
    assign Busy        = r_busy;
    assign Step_strobe = r_strobe;
    assign Done        = r_done;

endmodule
